// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// inst_sram_axi_rd_bridge_pkg: AXI constants and AR state encoding shared by the fetch bridge.
package inst_sram_axi_rd_bridge_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  typedef enum logic {AR_IDLE, AR_REQ} ar_state_e;
endpackage

// File: rtl/inst_sram_axi_rd_bridge.sv
// inst_sram_axi_rd_bridge: converts instruction SRAM-like fetches into single-beat in-order AXI4 reads.
module inst_sram_axi_rd_bridge
  import inst_sram_axi_rd_bridge_pkg::*;
#(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] AXI_ID    = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_rerr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  ar_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_dec;
  logic          w_unused;
  assign w_unused = ^inst_sram_wdata;
  assign arid     = AXI_ID;
  assign arlen    = 8'd0;
  assign arsize   = AXI_SIZE_4B;
  assign arburst  = AXI_BURST_INCR;
  assign rready   = !reset;
  assign addr_ok  = !reset && r_state == AR_IDLE && r_cnt < CW'(MAX_OUTST);
  assign w_accept = inst_sram_en && addr_ok;
  // a data_ok with nothing outstanding is a slave protocol error; hold the count at zero
  assign w_dec    = data_ok && r_cnt != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= AR_IDLE;
      arvalid <= 1'b0;
      araddr  <= '0;
    end else if (r_state == AR_IDLE) begin
      if (w_accept) begin
        r_state <= AR_REQ;
        arvalid <= 1'b1;
        araddr  <= inst_sram_addr;
      end
    end else if (arready) begin
      r_state <= AR_IDLE;
      arvalid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= r_cnt + CW'(w_accept) - CW'(w_dec);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok         <= 1'b0;
      inst_sram_rdata <= '0;
      inst_sram_rerr  <= 1'b0;
    end else begin
      data_ok <= rvalid;
      if (rvalid) begin
        inst_sram_rdata <= rdata;
        inst_sram_rerr  <= rresp != AXI_RESP_OKAY;
      end
    end
  end
`ifndef SYNTHESIS
  a_rlast: assert property (@(posedge clk) disable iff (reset) rvalid |-> rlast);
  a_rid:   assert property (@(posedge clk) disable iff (reset) rvalid |-> rid == AXI_ID);
  a_no_we: assert property (@(posedge clk) disable iff (reset) inst_sram_en |-> inst_sram_we == 4'h0);
`endif
endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// tb_inst_sram_axi_rd_bridge: directed fetch scenarios checked against a queue-based bridge model.
module tb_inst_sram_axi_rd_bridge;
  localparam int MAX = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok, data_ok, rerr, arvalid, rready;
  logic [31:0] rd_out, araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'h0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int ar_hs = 0;
  int hs0;
  always #5 clk = ~clk;
  inst_sram_axi_rd_bridge #(.MAX_OUTST(MAX), .AXI_ID(4'h0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(en), .inst_sram_we(we), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .inst_sram_rdata(rd_out), .inst_sram_rerr(rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  bit          m_ar_pend = 1'b0;
  logic [31:0] m_ar_addr = '0;
  logic [31:0] m_q[$];
  bit          m_dok = 1'b0;
  logic [31:0] m_rd = '0;
  bit          m_re = 1'b0;
  always @(posedge clk) begin : model
    bit acc;
    acc = en && !reset && !m_ar_pend && m_q.size() < MAX;
    if (!reset && arvalid && arready) ar_hs++;
    if (reset) begin
      m_ar_pend = 1'b0;
      m_ar_addr = '0;
      m_q.delete();
      m_dok = 1'b0;
      m_rd = '0;
      m_re = 1'b0;
    end else begin
      if (m_dok && m_q.size() > 0) void'(m_q.pop_front());
      if (m_ar_pend && arready) m_ar_pend = 1'b0;
      if (acc) begin
        m_ar_pend = 1'b1;
        m_ar_addr = addr;
        m_q.push_back(addr);
      end
      m_dok = rvalid;
      if (rvalid) begin
        m_rd = rdata;
        m_re = rresp != 2'b00;
      end
    end
  end
  always @(negedge clk) begin
    chk("addr_ok", addr_ok, !reset && !m_ar_pend && m_q.size() < MAX);
    chk("arvalid", arvalid, m_ar_pend);
    if (m_ar_pend) chk("araddr", araddr, m_ar_addr);
    chk("data_ok", data_ok, m_dok);
    if (m_dok) begin
      chk("rdata", rd_out, m_rd);
      chk("rerr", rerr, m_re);
    end
    chk("rready", rready, !reset);
    chk("ar_const", {arid, arlen, arsize, arburst}, {4'h0, 8'd0, 3'd2, 2'b01});
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  initial begin
    step();
    step();
    neg();
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rdata", rd_out, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_rready", rready, 0);
    step();
    reset = 1'b0;
    en = 1'b1; addr = 32'h1c000000; arready = 1'b1;
    neg(); chk("t1_addr_ok", addr_ok, 1);
    step(); en = 1'b0;
    neg(); chk("t1_arvalid", arvalid, 1); chk("t1_araddr", araddr, 32'h1c000000);
    step(); rvalid = 1'b1; rdata = 32'h02800000; rresp = 2'b00;
    neg(); chk("t1_no_dok_yet", data_ok, 0);
    step(); rvalid = 1'b0;
    neg(); chk("t1_data_ok", data_ok, 1); chk("t1_rdata", rd_out, 32'h02800000); chk("t1_rerr", rerr, 0);
    step();
    neg(); chk("t1_dok_pulse", data_ok, 0);
    step(); en = 1'b1; addr = 32'h1c000010; arready = 1'b0;
    step(); en = 1'b0; hs0 = ar_hs;
    for (int i = 0; i < 5; i++) begin
      neg(); chk("t2_arvalid", arvalid, 1); chk("t2_araddr", araddr, 32'h1c000010); chk("t2_addr_ok", addr_ok, 0);
      step();
    end
    arready = 1'b1;
    neg(); chk("t2_arvalid_hs", arvalid, 1);
    step(); rvalid = 1'b1; rdata = 32'h12345678;
    neg(); chk("t2_arvalid_drop", arvalid, 0); chk("t2_one_hs", ar_hs - hs0, 1);
    step(); rvalid = 1'b0;
    neg(); chk("t2_rdata", rd_out, 32'h12345678);
    step(); en = 1'b1; addr = 32'h1c000000;
    step(); addr = 32'h1c000004;
    neg(); chk("t3_busy", addr_ok, 0);
    step();
    neg(); chk("t3_second_ok", addr_ok, 1);
    step();
    neg(); chk("t3_araddr2", araddr, 32'h1c000004);
    step();
    neg(); chk("t3_full", addr_ok, 0);
    step(); rvalid = 1'b1; rdata = 32'hAAAA0000;
    neg(); chk("t3_full_hold", addr_ok, 0);
    step(); rvalid = 1'b0; en = 1'b0;
    neg(); chk("t4_dok1", data_ok, 1); chk("t4_word1", rd_out, 32'hAAAA0000); chk("t3_still_full", addr_ok, 0);
    step(); rvalid = 1'b1; rdata = 32'hBBBB0004;
    neg(); chk("t3_reopen", addr_ok, 1); chk("t4_gap", data_ok, 0);
    step(); rvalid = 1'b0;
    neg(); chk("t4_dok2", data_ok, 1); chk("t4_word2", rd_out, 32'hBBBB0004);
    step(); en = 1'b1; addr = 32'h1c000008;
    step(); en = 1'b0;
    step(); rvalid = 1'b1; rresp = 2'b10; rdata = 32'hCCCC0008;
    step(); rvalid = 1'b0; rresp = 2'b00; en = 1'b1; addr = 32'h1c00000c;
    neg(); chk("t5_dok_err", data_ok, 1); chk("t5_rerr", rerr, 1); chk("t5_accept_with_dok", addr_ok, 1);
    step(); en = 1'b0;
    neg(); chk("t5_araddr", araddr, 32'h1c00000c);
    step(); rvalid = 1'b1; rdata = 32'hDDDD000C;
    step(); rvalid = 1'b0;
    neg(); chk("t5_dok_ok", data_ok, 1); chk("t5_rerr_clear", rerr, 0); chk("t5_rdata", rd_out, 32'hDDDD000C);
    step(); rvalid = 1'b1; rdata = 32'hEEEE0000;
    step(); rvalid = 1'b0;
    neg(); chk("stray_dok", data_ok, 1);
    step();
    neg(); chk("stray_no_underflow", addr_ok, 1);
    step(); en = 1'b1; addr = 32'h1c000040;
    step(); en = 1'b0;
    step(); en = 1'b1; addr = 32'h1c000044; arready = 1'b0;
    step(); en = 1'b0;
    neg(); chk("t6_arvalid_pre", arvalid, 1);
    reset = 1'b1; rvalid = 1'b1; rdata = 32'h55555555;
    step();
    neg(); chk("t6_arvalid", arvalid, 0); chk("t6_addr_ok", addr_ok, 0); chk("t6_no_dok", data_ok, 0);
    step(); reset = 1'b0; rvalid = 1'b0;
    neg(); chk("t6_no_late_dok", data_ok, 0); chk("t6_cnt_clear", addr_ok, 1); chk("t6_arvalid_post", arvalid, 0);
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
